// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and types shared by the 5-stage MIPS core.
//   RegAddrBus / RegDataBus  - register address / data types
//   RegNum / RegNumLog2      - architectural register count and its log2
//   ZeroWord / NOPRegAddr    - zero data word and the hard-wired $0 address
//   Write*/Read*/RstEnable   - active levels of the enable and reset strobes
//   commits()                - true when a writeback actually changes state
package regfile_pkg;

    localparam int RegNum     = 32;
    localparam int RegNumLog2 = 5;
    localparam int RegAddrW   = 5;
    localparam int RegDataW   = 32;

    typedef logic [RegAddrW-1:0] RegAddrBus;
    typedef logic [RegDataW-1:0] RegDataBus;

    localparam RegDataBus ZeroWord   = '0;
    localparam RegAddrBus NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b1;

    // A writeback commits only when enabled and not aimed at $0; this one
    // rule drives both the array write and the retired-write counter.
    function automatic logic commits(input logic we, input RegAddrBus addr);
        return (we == WriteEnable) && (addr != NOPRegAddr);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one decode-stage read port of the register file.
//   rst             in   reset, forces the port to zero
//   re / raddr      in   port enable and register address
//   wb_wreg_enable  in   writeback enable for the bypass compare
//   wb_wreg_addr    in   writeback destination for the bypass compare
//   wb_wdata        in   writeback data, forwarded on an address hit
//   stored          in   committed array value at raddr
//   rdata           out  read data, combinational
module regfile_rdport
    import regfile_pkg::*;
(
    input  logic      rst,
    input  logic      re,
    input  RegAddrBus raddr,
    input  logic      wb_wreg_enable,
    input  RegAddrBus wb_wreg_addr,
    input  RegDataBus wb_wdata,
    input  RegDataBus stored,
    output RegDataBus rdata
);

    // The $0 check precedes the bypass, so a writeback aimed at $0 can never
    // leak onto the port even though it would match the address.
    always_comb begin
        rdata = ZeroWord;
        if (rst == RstEnable) begin
            rdata = ZeroWord;
        end else if (re == ReadDisable) begin
            rdata = ZeroWord;
        end else if (raddr == NOPRegAddr) begin
            rdata = ZeroWord;
        end else if ((wb_wreg_enable == WriteEnable) && (wb_wreg_addr == raddr)) begin
            // Same-cycle forwarding closes the WB->ID hazard without a stall.
            rdata = wb_wdata;
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32 general-purpose register file of the 5-stage MIPS core.
//   clk, rst                    clock and synchronous active-high reset
//   wb_wreg_enable/addr, wb_wdata  writeback port from MEM/WB
//   re1/raddr1 -> rdata1        decode read port 1 (bypassed, combinational)
//   re2/raddr2 -> rdata2        decode read port 2 (bypassed, combinational)
//   dbg_raddr -> dbg_rdata      debug read of committed state (no bypass)
//   wr_count                    number of committed writes, wraps at 2^32
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_wreg_enable,
    input  RegAddrBus wb_wreg_addr,
    input  RegDataBus wb_wdata,
    input  logic      re1,
    input  RegAddrBus raddr1,
    output RegDataBus rdata1,
    input  logic      re2,
    input  RegAddrBus raddr2,
    output RegDataBus rdata2,
    input  RegAddrBus dbg_raddr,
    output RegDataBus dbg_rdata,
    output RegDataBus wr_count
);

    // $0 has no storage; every lookup guards address 0 before indexing.
    RegDataBus regs [1:RegNum-1];
    RegDataBus count;
    RegDataBus stored1;
    RegDataBus stored2;

    function automatic RegDataBus lookup(input RegAddrBus addr);
        RegDataBus value;
        value = ZeroWord;
        if (addr != NOPRegAddr) begin
            value = regs[addr];
        end
        return value;
    endfunction

    // Reset wins over a coincident writeback, so no partial write survives.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 1; i < RegNum; i++) begin
                regs[i] <= ZeroWord;
            end
            count <= ZeroWord;
        end else if (commits(wb_wreg_enable, wb_wreg_addr)) begin
            regs[wb_wreg_addr] <= wb_wdata;
            count              <= count + 32'd1;
        end
    end

    assign stored1 = lookup(raddr1);
    assign stored2 = lookup(raddr2);

    regfile_rdport u_rdport1 (
        .rst            (rst),
        .re             (re1),
        .raddr          (raddr1),
        .wb_wreg_enable (wb_wreg_enable),
        .wb_wreg_addr   (wb_wreg_addr),
        .wb_wdata       (wb_wdata),
        .stored         (stored1),
        .rdata          (rdata1)
    );

    regfile_rdport u_rdport2 (
        .rst            (rst),
        .re             (re2),
        .raddr          (raddr2),
        .wb_wreg_enable (wb_wreg_enable),
        .wb_wreg_addr   (wb_wreg_addr),
        .wb_wdata       (wb_wdata),
        .stored         (stored2),
        .rdata          (rdata2)
    );

    // The debug port deliberately skips the bypass: it shows committed state.
    assign dbg_rdata = (rst == RstEnable) ? ZeroWord : lookup(dbg_raddr);
    assign wr_count  = count;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: table-driven bench for regfile. Each row is one clock cycle:
// inputs are driven after the falling edge, the expected outputs for that
// cycle go into a scoreboard queue, and they are popped and compared just
// before the next rising edge commits the cycle.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        wb_wreg_enable;
    logic [4:0]  wb_wreg_addr;
    logic [31:0] wb_wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] wr_count;

    regfile dut (
        .clk            (clk),
        .rst            (rst),
        .wb_wreg_enable (wb_wreg_enable),
        .wb_wreg_addr   (wb_wreg_addr),
        .wb_wdata       (wb_wdata),
        .re1            (re1),
        .raddr1         (raddr1),
        .rdata1         (rdata1),
        .re2            (re2),
        .raddr2         (raddr2),
        .rdata2         (rdata2),
        .dbg_raddr      (dbg_raddr),
        .dbg_rdata      (dbg_rdata),
        .wr_count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [4:0]  da;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [31:0] ec;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [31:0] ec;
    } exp_t;

    vec_t vecs [$];
    vec_t wrap [$];
    exp_t sb   [$];
    int   checks = 0;
    int   errors = 0;

    task automatic compare(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %h required %h", name, idx, act, req);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst            = v.rst;
        wb_wreg_enable = v.we;
        wb_wreg_addr   = v.wa;
        wb_wdata       = v.wd;
        re1            = v.re1;
        raddr1         = v.ra1;
        re2            = v.re2;
        raddr2         = v.ra2;
        dbg_raddr      = v.da;
        sb.push_back('{idx, v.e1, v.e2, v.ed, v.ec});
        #2;
        if (sb.size() == 0) begin
            compare("scoreboard_empty", idx, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            compare("rdata1",    e.idx, rdata1,    e.e1);
            compare("rdata2",    e.idx, rdata2,    e.e2);
            compare("dbg_rdata", e.idx, dbg_rdata, e.ed);
            compare("wr_count",  e.idx, wr_count,  e.ec);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst we wa  wd            re1 ra1 re2 ra2 da  rdata1        rdata2        dbg           count
        vecs.push_back('{1, 1, 5, 32'h0000_0099, 1, 5, 1, 5, 5, 32'h0,         32'h0,         32'h0,         32'd0});
        vecs.push_back('{0, 1, 3, 32'hDEAD_BEEF, 1, 3, 1, 3, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'd0});
        vecs.push_back('{0, 0, 0, 32'h0,         1, 3, 0, 3, 3, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 32'd1});
        vecs.push_back('{0, 1, 7, 32'hA5A5_0001, 1, 7, 1, 7, 7, 32'hA5A5_0001, 32'hA5A5_0001, 32'h0,         32'd1});
        vecs.push_back('{0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 7, 0, 32'h0,         32'hA5A5_0001, 32'h0,         32'd2});
        vecs.push_back('{0, 0, 0, 32'h0,         1, 0, 1, 3, 7, 32'h0,         32'hDEAD_BEEF, 32'hA5A5_0001, 32'd2});
        vecs.push_back('{0, 0, 0, 32'h0,         1, 7, 1, 3, 0, 32'hA5A5_0001, 32'hDEAD_BEEF, 32'h0,         32'd2});
        vecs.push_back('{0, 1, 9, 32'h0000_0001, 1, 9, 0, 9, 9, 32'h1,         32'h0,         32'h0,         32'd2});
        vecs.push_back('{0, 1, 9, 32'h0000_0002, 1, 9, 1, 9, 9, 32'h2,         32'h2,         32'h1,         32'd3});
        vecs.push_back('{0, 0, 9, 32'h0000_0077, 1, 9, 1, 3, 9, 32'h2,         32'hDEAD_BEEF, 32'h2,         32'd4});
        vecs.push_back('{0, 1, 5, 32'h0000_1234, 1, 5, 1, 9, 5, 32'h1234,      32'h2,         32'h0,         32'd4});
        vecs.push_back('{0, 1, 3, 32'h0000_1111, 1, 3, 0, 3, 3, 32'h1111,      32'h0,         32'hDEAD_BEEF, 32'd5});
        vecs.push_back('{0, 0, 0, 32'h0,         1, 3, 1, 5, 5, 32'h1111,      32'h1234,      32'h1234,      32'd6});
        vecs.push_back('{1, 1, 4, 32'h0000_0055, 1, 5, 1, 4, 5, 32'h0,         32'h0,         32'h0,         32'd6});
        vecs.push_back('{0, 0, 0, 32'h0,         1, 4, 1, 5, 4, 32'h0,         32'h0,         32'h0,         32'd0});
        vecs.push_back('{0, 0, 0, 32'h0,         1, 3, 1, 9, 5, 32'h0,         32'h0,         32'h0,         32'd0});

        wrap.push_back('{0, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF});
        wrap.push_back('{0, 1, 6, 32'h00C0_FFEE, 1, 6, 0, 0, 6, 32'h00C0_FFEE, 32'h0,         32'h0,         32'hFFFF_FFFF});
        wrap.push_back('{0, 0, 0, 32'h0,         1, 6, 1, 6, 6, 32'h00C0_FFEE, 32'h00C0_FFEE, 32'h00C0_FFEE, 32'd0});

        // Initial reset so that the first table row sees a cleared counter.
        rst            = 1'b1;
        wb_wreg_enable = 1'b0;
        wb_wreg_addr   = '0;
        wb_wdata       = '0;
        re1            = 1'b0;
        raddr1         = '0;
        re2            = 1'b0;
        raddr2         = '0;
        dbg_raddr      = '0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Counter wrap: preload the counter through a brief force, then one
        // committed write must roll it over to zero.
        @(negedge clk);
        force dut.count = 32'hFFFF_FFFF;
        #1;
        release dut.count;
        for (int i = 0; i < wrap.size(); i++) begin
            apply(wrap[i], 100 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file for the 5-stage MIPS core: the consuming end of the writeback interface driven by the MEM/WB pipeline register. It holds the 32 architectural registers, accepts one write per cycle from the writeback stage, and serves two decode-stage read ports with same-cycle write-to-read bypass. It also exposes a debug read port and a retired-write counter for the test harness.

## Interface
- `RegNum`, 32: number of architectural registers, fixed.
- `RegAddrW`, 5: register address width.
- `RegDataW`, 32: register data width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wb_wreg_enable`  in  1  writeback write enable (from MEM/WB).
- `wb_wreg_addr`  in  5  writeback destination register.
- `wb_wdata`  in  32  writeback data.
- `re1`  in  1  read port 1 enable (decode stage).
- `raddr1`  in  5  read port 1 address.
- `rdata1`  out  32  read port 1 data, combinational.
- `re2`  in  1  read port 2 enable.
- `raddr2`  in  5  read port 2 address.
- `rdata2`  out  32  read port 2 data, combinational.
- `dbg_raddr`  in  5  debug read address, no bypass.
- `dbg_rdata`  out  32  debug read data, combinational.
- `wr_count`  out  32  count of committed register writes.

## Operation
- Storage: 32 × 32-bit array; `$0` is not stored and always reads 0.
- Write: on a rising `clk` with `rst`=0 and `wb_wreg_enable`=1 and `wb_wreg_addr`≠0, `regs[wb_wreg_addr]` <= `wb_wdata`. Writes to `$0` are discarded.
- Read port n (same rules for ports 1 and 2), in priority order:
  - `rst`=1 -> 0.
  - `re`n=0 -> 0.
  - `raddr`n=0 -> 0.
  - `wb_wreg_enable`=1 and `wb_wreg_addr`=`raddr`n -> `wb_wdata` (bypass).
  - Otherwise -> `regs[raddr`n`]`.
- Both read ports may address the same register and must both get the bypassed value.
- Debug port: `dbg_raddr`=0 or `rst`=1 -> 0; otherwise returns the array value directly, with no bypass (it shows committed state).
- `wr_count`:
  - Increments by 1 on each committed write (enable=1, addr≠0).
  - Wraps from 0xFFFF_FFFF to 0.
  - Does not count writes to `$0`, or cycles with enable=0.

## Timing
- Reset (`rst`=1 at a rising edge):
  - All 31 stored registers go to 0x0000_0000 and `wr_count` goes to 0.
  - While `rst` is high, `rdata1`, `rdata2` and `dbg_rdata` are 0.
  - A write presented in the same cycle as `rst` is dropped.
  - Mid-operation reset discards all state with no partial writes.
- Write latency: one edge. The value is visible on `dbg_rdata` in the cycle after the edge, and on `rdata1`/`rdata2` in the same cycle through the bypass.
- Read latency: zero cycles (combinational). This is required so that a decode in cycle N sees a writeback in cycle N, which closes the WB→ID hazard without a stall.
- There is no handshake. The MEM/WB register's bubble (addr 0, enable 0, data 0) must cause no write and no counter change.
- Back-to-back writes to the same register each commit in order. The last write wins, and the counter increments once per write.

## Structure
- Shared constants belong in the core's shared constants header:
  - `RegAddrBus`, `RegDataBus`, `RegNum`, `RegNumLog2`
  - `ZeroWord`, `NOPRegAddr`
  - `WriteEnable`/`WriteDisable`, `ReadEnable`/`ReadDisable`, `RstEnable`
- One sub-module is natural: `regfile_rdport`, the combinational read-mux plus bypass logic. It is instantiated twice, for ports 1 and 2.
- The array, write logic, debug port and counter live in the top module.

## Test plan
- **Reset clears state:** preload `$5`=0x1234, then hold `rst`=1 for 1 cycle -> `dbg_rdata`(5)=0, `wr_count`=0, and `rdata1`=0 during reset.
- **Write then read:** write `$3`=0xDEAD_BEEF -> next cycle `rdata1`(`raddr1`=3, `re1`=1)=0xDEAD_BEEF, `dbg_rdata`(3)=0xDEAD_BEEF, `wr_count`=1. With `re1`=0 the same read gives 0.
- **Bypass, both ports:** same cycle as the write of `$7`=0xA5A5_0001, `raddr1`=`raddr2`=7 -> both ports read 0xA5A5_0001 while `dbg_rdata`(7) still shows the old value (0).
- **Zero register:** write `$0`=0xFFFF_FFFF with enable=1 -> `rdata1`(0)=0 in that cycle and the next, `wr_count` unchanged.
- **Bubble and back-to-back writes:**
  - Bubble (enable=0, addr=0, data=0) -> no change.
  - Then `$9`=1 followed by `$9`=2 on consecutive edges -> `dbg_rdata`(9)=2, `wr_count` +2.
- **Counter wrap and reset during write:**
  - Force `wr_count` to 0xFFFF_FFFF via 2^32−1 writes (or a backdoor preload), then one more write -> `wr_count`=0.
  - Assert `rst` together with a write of `$4`=0x55 -> `$4`=0 after the edge.
